fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Owns the program counter and sequences instruction fetch for the pipeline IF stage.
//  Issues one instruction-memory request at a time and presents the fetched instruction
//    to IF/ID with a valid flag.
//  Honours stall requests from the hazard unit.
//  Redirects on branch or jump with the same priority as the next-PC select:
//    branch > jump > pc+4.
//    Wrong-path responses that are still in flight are discarded.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset; the first fetch address
// PORTS
//  clk           in   1   system clock, rising edge
//  reset         in   1   synchronous, active-high reset
//  stall         in   1   hazard unit: IF/ID must hold the current instruction
//  br_taken      in   1   branch resolved taken (PCSrc)
//  br_target     in   32  branch target address
//  jump          in   1   jump resolved
//  jump_target   in   32  absolute jump address
//  imem_req      out  1   fetch request
//  imem_addr     out  32  fetch address; word aligned
//  imem_ready    in   1   memory accepts the request this cycle
//  imem_rvalid   in   1   read data valid; one response per accepted request, in order
//  imem_rdata    in   32  instruction word
//  if_valid      out  1   if_instr/if_pc hold a valid instruction
//  if_instr      out  32  fetched instruction
//  if_pc         out  32  address of if_instr
//  if_pc_plus_4  out  32  if_pc + 4
// BEHAVIOUR
//  Reset
//    pc=RESET_PC, state=IDLE, kill=0.
//    imem_req=0, if_valid=0, if_instr=0, if_pc=0, if_pc_plus_4=4.
//  States: IDLE, REQ, RESP, HOLD. All outputs are registered except imem_req and imem_addr.
//    imem_req=(state==REQ). imem_addr=pc.
//  IDLE -> REQ unconditionally. This gives 1 cycle of bubble after reset.
//  REQ: request is accepted when imem_ready=1; the next state is RESP.
//    imem_addr may change before acceptance. The memory samples it only when ready=1.
//  RESP: wait for imem_rvalid.
//    kill=1: discard the data, clear kill, go to REQ. pc already holds the redirect target.
//    kill=0: latch if_instr=rdata, if_pc=pc, if_pc_plus_4=pc+4. Set if_valid=1. Go to HOLD.
//    Latency from acceptance to if_valid is memory latency + 1 cycle.
//  HOLD: outputs are held while stall=1.
//    With stall=0, ID consumes the instruction this cycle.
//    Next cycle: if_valid=0, pc=pc+4, state REQ.
//  Redirect: redir = br_taken|jump. Target is br_target if br_taken, else jump_target.
//    Redirect takes priority over stall and over the normal pc+4 advance, in every state
//      except IDLE.
//    It is ignored in IDLE and while reset=1.
//    REQ, ready=0: pc=target. The request continues with the new address.
//    REQ, ready=1 (old address accepted): pc=target, kill=1, go to RESP.
//    RESP, rvalid=0: pc=target, kill=1.
//    RESP, rvalid=1: discard the data, pc=target, kill=0, go to REQ.
//    HOLD: pc=target, if_valid=0 next cycle, go to REQ. The held instruction is dropped.
//  Arithmetic: pc+4 is mod 2^32. 32'hFFFF_FFFC wraps to 0 with no error.
//  Targets are used as given. Bits [1:0] are not checked; alignment is the producer's job.
//  Reset mid-request: the in-flight response is not tracked. After reset, the IDLE cycle
//    and the memory contract (no response without a post-reset accept) make it harmless.
// TESTING
//  T1 reset
//    -> first request is at 32'h0 in cycle 2.
//    -> with a 1-cycle memory, if_valid rises with if_pc=0.
//    -> stream 0,4,8 follows, one instruction every 3 cycles.
//  T2 stall=1 for 4 cycles in HOLD at if_pc=8
//    -> if_instr and if_pc are stable.
//    -> no imem_req during the stall.
//    -> stall drops; next request is at 12.
//  T3 br_taken=1, br_target=0x100 while RESP is pending for 0x10
//    -> response for 0x10 is discarded (if_valid stays 0).
//    -> next request is at 0x100.
//  T4 br_taken=1 (0x200) and jump=1 (0x300) in the same cycle
//    -> next fetch is at 0x200.
//    -> a redirect during stall in HOLD drops the held instruction.
//  T5 RESET_PC=32'hFFFF_FFFC
//    -> fetches FFFF_FFFC, then 0.
//    -> if_pc_plus_4=0 for the first instruction.
//  T6 reset asserted in RESP, and separately in HOLD
//    -> next cycle if_valid=0, imem_req=0.
//    -> refetch starts at RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer.sv
// IF-stage fetch sequencer: owns the PC, issues one imem request at a time and
// presents the fetched instruction to IF/ID, with branch/jump redirect and stall.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus_4
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, HOLD} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n, pc_plus_4;
  logic        kill, kill_n;
  logic        valid_n;
  logic [31:0] instr_n, ifpc_n, ifpc4_n;
  logic        redir;
  logic [31:0] target;

  assign imem_req  = (state == REQ);
  assign imem_addr = pc;
  assign pc_plus_4 = pc + 32'd4;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      kill         <= 1'b0;
      if_valid     <= 1'b0;
      if_instr     <= '0;
      if_pc        <= '0;
      if_pc_plus_4 <= 32'd4;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      kill         <= kill_n;
      if_valid     <= valid_n;
      if_instr     <= instr_n;
      if_pc        <= ifpc_n;
      if_pc_plus_4 <= ifpc4_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    kill_n  = kill;
    valid_n = if_valid;
    instr_n = if_instr;
    ifpc_n  = if_pc;
    ifpc4_n = if_pc_plus_4;
    redir   = br_taken | jump;
    target  = br_taken ? br_target : jump_target;

    case (state)
      IDLE: state_n = REQ;
      REQ: begin
        if (imem_ready) begin
          state_n = RESP;
          // Old address already accepted: its response must be dropped.
          if (redir) begin
            pc_n   = target;
            kill_n = 1'b1;
          end
        end else if (redir) begin
          pc_n = target;
        end
      end
      RESP: begin
        if (imem_rvalid) begin
          state_n = REQ;
          kill_n  = 1'b0;
          if (redir) begin
            pc_n = target;
          end else if (!kill) begin
            state_n = HOLD;
            valid_n = 1'b1;
            instr_n = imem_rdata;
            ifpc_n  = pc;
            ifpc4_n = pc_plus_4;
          end
        end else if (redir) begin
          pc_n   = target;
          kill_n = 1'b1;
        end
      end
      HOLD: begin
        if (redir) begin
          pc_n    = target;
          valid_n = 1'b0;
          state_n = REQ;
        end else if (!stall) begin
          pc_n    = pc_plus_4;
          valid_n = 1'b0;
          state_n = REQ;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: two instances (RESET_PC 0 and FFFF_FFFC)
// share stimulus; each has its own in-order single-outstanding memory model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic        imem_ready = 1'b1;

  logic        imem_req, imem_rvalid, if_valid;
  logic [31:0] imem_addr, imem_rdata, if_instr, if_pc, if_pc_plus_4;
  logic        b_req, b_rvalid, b_valid;
  logic [31:0] b_addr, b_rdata, b_instr, b_pc, b_pc4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .br_taken(br_taken), .br_target(br_target), .jump(jump), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus_4(if_pc_plus_4)
  );

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .stall(stall),
    .br_taken(br_taken), .br_target(br_target), .jump(jump), .jump_target(jump_target),
    .imem_req(b_req), .imem_addr(b_addr), .imem_ready(imem_ready),
    .imem_rvalid(b_rvalid), .imem_rdata(b_rdata),
    .if_valid(b_valid), .if_instr(b_instr), .if_pc(b_pc), .if_pc_plus_4(b_pc4)
  );

  // Memory for dut: response mem_lat cycles after acceptance; data = C0DE_xxxx.
  int          cyc = 0;
  int          mem_lat = 1;
  logic        a_pend = 1'b0;
  logic [31:0] a_addr = '0;
  int          a_due = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) a_pend <= 1'b0;
    else if (imem_req && imem_ready) begin
      a_pend <= 1'b1;
      a_addr <= imem_addr;
      a_due  <= cyc + mem_lat;
    end else if (imem_rvalid) a_pend <= 1'b0;
  end
  assign imem_rvalid = a_pend && (cyc >= a_due);
  assign imem_rdata  = imem_rvalid ? (32'hC0DE_0000 | {16'h0, a_addr[15:0]}) : '0;

  logic        b_pend = 1'b0;
  logic [31:0] b_maddr = '0;
  always @(posedge clk) begin
    if (reset) b_pend <= 1'b0;
    else if (b_req && imem_ready) begin
      b_pend  <= 1'b1;
      b_maddr <= b_addr;
    end else if (b_rvalid) b_pend <= 1'b0;
  end
  assign b_rvalid = b_pend;
  assign b_rdata  = b_rvalid ? (32'hC0DE_0000 | {16'h0, b_maddr[15:0]}) : '0;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", if_valid); end
    checks++; if (if_instr !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=0", if_instr); end
    checks++; if (if_pc !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=0", if_pc); end
    checks++; if (if_pc_plus_4 !== 32'h4) begin failures++; $display("FAIL rst_pc4 got=%h exp=4", if_pc_plus_4); end
    reset = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] a;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL t1_first_req got=%b/%h exp=1/0", imem_req, imem_addr); end
    step();
    checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin failures++; $display("FAIL t1_resp got=%b/%b exp=0/0", imem_req, if_valid); end
    step();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'hC0DE_0000) begin failures++; $display("FAIL t1_first_out got=%b/%h/%h exp=1/0/c0de0000", if_valid, if_pc, if_instr); end
    checks++; if (if_pc_plus_4 !== 32'h4) begin failures++; $display("FAIL t1_first_pc4 got=%h exp=4", if_pc_plus_4); end
    for (int i = 1; i <= 2; i++) begin
      a = 32'(4 * i);
      step();
      checks++; if (imem_req !== 1'b1 || imem_addr !== a || if_valid !== 1'b0) begin failures++; $display("FAIL t1_req%0d got=%b/%h/%b exp=1/%h/0", i, imem_req, imem_addr, if_valid, a); end
      step();
      step();
      checks++; if (if_valid !== 1'b1 || if_pc !== a || if_instr !== (32'hC0DE_0000 | a)) begin failures++; $display("FAIL t1_out%0d got=%b/%h/%h exp=1/%h", i, if_valid, if_pc, if_instr, a); end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    repeat (4) begin
      step();
      checks++; if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== 32'hC0DE_0008) begin failures++; $display("FAIL t2_hold got=%b/%b/%h/%h exp=0/1/8/c0de0008", imem_req, if_valid, if_pc, if_instr); end
    end
    stall = 1'b0;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC || if_valid !== 1'b0) begin failures++; $display("FAIL t2_resume got=%b/%h/%b exp=1/c/0", imem_req, imem_addr, if_valid); end
  endtask

  task automatic test_branch_kill();
    step();
    step();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'hC) begin failures++; $display("FAIL t3_pre got=%b/%h exp=1/c", if_valid, if_pc); end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin failures++; $display("FAIL t3_req10 got=%b/%h exp=1/10", imem_req, imem_addr); end
    mem_lat = 3;
    step();
    br_taken = 1'b1; br_target = 32'h100;
    step();
    br_taken = 1'b0;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h100 || if_valid !== 1'b0) begin failures++; $display("FAIL t3_redir got=%b/%h/%b exp=0/100/0", imem_req, imem_addr, if_valid); end
    step();
    checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL t3_wait got=%b/%b exp=0/0", if_valid, imem_req); end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || if_valid !== 1'b0) begin failures++; $display("FAIL t3_discard got=%b/%h/%b exp=1/100/0", imem_req, imem_addr, if_valid); end
    mem_lat = 1;
    step();
    step();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== 32'hC0DE_0100 || if_pc_plus_4 !== 32'h104) begin failures++; $display("FAIL t3_out got=%b/%h/%h/%h exp=1/100/c0de0100/104", if_valid, if_pc, if_instr, if_pc_plus_4); end
  endtask

  task automatic test_priority();
    stall = 1'b1; br_taken = 1'b1; br_target = 32'h200; jump = 1'b1; jump_target = 32'h300;
    step();
    stall = 1'b0; br_taken = 1'b0; jump = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200 || if_valid !== 1'b0) begin failures++; $display("FAIL t4_br_over_jump got=%b/%h/%b exp=1/200/0", imem_req, imem_addr, if_valid); end
    step();
    step();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_instr !== 32'hC0DE_0200) begin failures++; $display("FAIL t4_out got=%b/%h/%h exp=1/200/c0de0200", if_valid, if_pc, if_instr); end
    jump = 1'b1; jump_target = 32'h300;
    step();
    jump = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin failures++; $display("FAIL t4_jump got=%b/%h exp=1/300", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_req();
    imem_ready = 1'b0; br_taken = 1'b1; br_target = 32'h400;
    step();
    br_taken = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin failures++; $display("FAIL req_unaccepted got=%b/%h exp=1/400", imem_req, imem_addr); end
    imem_ready = 1'b1;
    step();
    step();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h400 || if_instr !== 32'hC0DE_0400) begin failures++; $display("FAIL req_unacc_out got=%b/%h/%h exp=1/400/c0de0400", if_valid, if_pc, if_instr); end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h404) begin failures++; $display("FAIL req_next got=%b/%h exp=1/404", imem_req, imem_addr); end
    br_taken = 1'b1; br_target = 32'h500;
    step();
    br_taken = 1'b0;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h500 || if_valid !== 1'b0) begin failures++; $display("FAIL req_accepted_redir got=%b/%h/%b exp=0/500/0", imem_req, imem_addr, if_valid); end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h500 || if_valid !== 1'b0) begin failures++; $display("FAIL req_killed got=%b/%h/%b exp=1/500/0", imem_req, imem_addr, if_valid); end
    step();
    step();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h500 || if_instr !== 32'hC0DE_0500) begin failures++; $display("FAIL req_kill_out got=%b/%h/%h exp=1/500/c0de0500", if_valid, if_pc, if_instr); end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL t6_hold_rst got=%b/%b exp=0/0", if_valid, imem_req); end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL t6_refetch1 got=%b/%h exp=1/0", imem_req, imem_addr); end
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL t6_resp_rst got=%b/%b exp=0/0", if_valid, imem_req); end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL t6_refetch2 got=%b/%h exp=1/0", imem_req, imem_addr); end
    step();
    step();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'hC0DE_0000) begin failures++; $display("FAIL t6_out got=%b/%h/%h exp=1/0/c0de0000", if_valid, if_pc, if_instr); end
  endtask

  task automatic test_wrap();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (b_req !== 1'b0 || b_valid !== 1'b0 || b_pc4 !== 32'h4) begin failures++; $display("FAIL t5_rst got=%b/%b/%h exp=0/0/4", b_req, b_valid, b_pc4); end
    step();
    checks++; if (b_req !== 1'b1 || b_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL t5_req got=%b/%h exp=1/fffffffc", b_req, b_addr); end
    step();
    step();
    checks++; if (b_valid !== 1'b1 || b_pc !== 32'hFFFF_FFFC || b_instr !== 32'hC0DE_FFFC) begin failures++; $display("FAIL t5_out got=%b/%h/%h exp=1/fffffffc/c0defffc", b_valid, b_pc, b_instr); end
    checks++; if (b_pc4 !== 32'h0) begin failures++; $display("FAIL t5_pc4 got=%h exp=0", b_pc4); end
    step();
    checks++; if (b_req !== 1'b1 || b_addr !== 32'h0) begin failures++; $display("FAIL t5_wrap got=%b/%h exp=1/0", b_req, b_addr); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_branch_kill();
    test_priority();
    test_redirect_req();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
